// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer: queues (pattern, duty) commands and launches them one
// frame at a time into a PWM engine, with optional looping, gaps and timeout.
module pattern_seq_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_pat,
  input  logic [7:0]             cmd_duty,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  input  logic                   loop_en,
  input  logic [7:0]             gap_num,
  output logic                   pwm_en,
  output logic [7:0]             pat_out,
  output logic [7:0]             duty_out,
  input  logic                   pwm_busy,
  input  logic                   pwm_valid,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  localparam int unsigned GW = TW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, ext_addr_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            pwm_en_q, pwm_en_d;
  logic [7:0]      pat_q, pat_d, duty_q, duty_d;
  logic            seq_busy_q, seq_busy_d, seq_done_q, seq_done_d;
  logic            err_q, err_d, stop_pend_q, stop_pend_d;
  logic            pop_c, push_loop_c, push_ext_c, flush_c, ready_c;
  logic [15:0]     head_c;

  assign head_c  = mem_q[rd_ptr_q];
  assign flush_c = flush && (state_q == S_IDLE);
  assign ready_c = (cnt_q < CW'(DEPTH)) && !(loop_en && seq_busy_q);

  // Sequencer FSM; launch outputs are registered on the edge entering LAUNCH.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q | (stop && (state_q != S_IDLE));
    pop_c       = 1'b0;
    pwm_en_d    = 1'b0;
    pat_d       = pat_q;
    duty_d      = duty_q;
    seq_busy_d  = seq_busy_q;
    seq_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (cnt_q != '0) && !flush_c) begin
          state_d = S_LAUNCH;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        tcnt_d  = '0;
      end
      S_WAIT_BUSY: begin
        if (pwm_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (pwm_valid) begin
          state_d = S_GAP;
          tcnt_d  = '0;
        end
      end
      S_GAP: begin
        // gap_num of zero still spends one cycle here
        if ((GW'(tcnt_q) + GW'(1)) >= GW'(gap_num)) begin
          if ((cnt_q != '0) && !stop_pend_q && !stop) state_d = S_LAUNCH;
          else                                        state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_pend_d = 1'b0;

    if (state_d == S_LAUNCH) begin
      pop_c    = 1'b1;
      pwm_en_d = 1'b1;
      pat_d    = head_c[15:8];
      duty_d   = head_c[7:0];
    end
    seq_busy_d = (state_d != S_IDLE);
    seq_done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  // FIFO pointers/count; a looped entry and an external push may land together.
  always_comb begin
    push_loop_c = pop_c && loop_en;
    push_ext_c  = cmd_valid && ready_c && !flush_c;
    ext_addr_c  = wr_ptr_q + AW'(push_loop_c);
    rd_ptr_d    = rd_ptr_q + AW'(pop_c);
    wr_ptr_d    = wr_ptr_q + AW'(push_loop_c) + AW'(push_ext_c);
    cnt_d       = cnt_q + CW'(push_ext_c) + CW'(push_loop_c) - CW'(pop_c);
    if (flush_c) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_loop_c) mem_q[wr_ptr_q]   <= head_c;
    if (push_ext_c)  mem_q[ext_addr_c] <= {cmd_pat, cmd_duty};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      pwm_en_q    <= 1'b0;
      pat_q       <= '0;
      duty_q      <= '0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      pwm_en_q    <= pwm_en_d;
      pat_q       <= pat_d;
      duty_q      <= duty_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign cmd_ready = ready_c;
  assign pwm_en    = pwm_en_q;
  assign pat_out   = pat_q;
  assign duty_out  = duty_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign fifo_cnt  = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Self-checking bench for pattern_seq_ctrl with a reactive PWM engine model
// and a launch scoreboard.
module tb_pattern_seq_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [7:0] cmd_pat = 8'h0;
  logic [7:0] cmd_duty = 8'h0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic flush = 1'b0;
  logic loop_en = 1'b0;
  logic [7:0] gap_num = 8'h0;
  logic pwm_en;
  logic [7:0] pat_out, duty_out;
  logic pwm_busy = 1'b0;
  logic pwm_valid = 1'b0;
  logic seq_busy, seq_done, err;
  logic [$clog2(DEPTH):0] fifo_cnt;

  pattern_seq_ctrl #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pat(cmd_pat), .cmd_duty(cmd_duty), .start(start), .stop(stop),
    .flush(flush), .loop_en(loop_en), .gap_num(gap_num), .pwm_en(pwm_en),
    .pat_out(pat_out), .duty_out(duty_out), .pwm_busy(pwm_busy),
    .pwm_valid(pwm_valid), .seq_busy(seq_busy), .seq_done(seq_done),
    .fifo_cnt(fifo_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_launch = 0;
  int last_en_cyc = 0;
  int valid_cyc = 0;
  int eng_left = 0;
  int eng_len = 3;
  int mon_gap;
  bit have_valid = 1'b0;
  bit eng_dead = 1'b0;
  logic [15:0] mon_exp;
  logic [15:0] sb_q[$];

  // Engine model and launch scoreboard
  always @(negedge clk) begin
    pwm_valid = 1'b0;
    if (!rst_n) begin
      pwm_busy = 1'b0;
      eng_left = 0;
      have_valid = 1'b0;
    end else begin
      if (seq_done) have_valid = 1'b0;
      if (pwm_en) begin
        n_launch++;
        last_en_cyc = cyc;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL launch_unexpected: pat_out=%h duty_out=%h, no command queued", pat_out, duty_out);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({pat_out, duty_out} !== mon_exp) begin
            n_errors++;
            $display("FAIL launch_data: got %h expected %h", {pat_out, duty_out}, mon_exp);
          end
          if (loop_en) sb_q.push_back(mon_exp);
        end
        if (have_valid) begin
          mon_gap = (gap_num == 8'd0) ? 2 : int'(gap_num) + 1;
          n_checks++;
          if ((cyc - valid_cyc) !== mon_gap) begin
            n_errors++;
            $display("FAIL launch_spacing: got %0d cycles after pwm_valid expected %0d", cyc - valid_cyc, mon_gap);
          end
        end
        have_valid = 1'b0;
        if (!eng_dead) begin
          pwm_busy = 1'b1;
          eng_left = eng_len;
        end
      end else if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin
          pwm_busy = 1'b0;
          pwm_valid = 1'b1;
          valid_cyc = cyc;
          have_valid = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] p, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_pat = p;
    cmd_duty = d;
    #1;
    if (cmd_ready) sb_q.push_back({p, d});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_seq_done(output bit seen, output int done_cyc);
    seen = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (seq_done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({pwm_en, seq_busy, seq_done, err} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000", {pwm_en, seq_busy, seq_done, err});
    end
    n_checks++;
    if ({pat_out, duty_out} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 0000", {pat_out, duty_out});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({cmd_ready, fifo_cnt} !== {1'b1, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_ready_cnt: got ready=%b cnt=%0d expected ready=1 cnt=0", cmd_ready, fifo_cnt);
    end
  endtask

  task automatic test_basic();
    bit seen;
    int dc;
    int base;
    bit ok;
    gap_num = 8'd2;
    push_one(8'hA5, 8'd3);
    n_checks++;
    if (fifo_cnt !== 3'd1) begin
      n_errors++;
      $display("FAIL basic_cnt1: got %0d expected 1", fifo_cnt);
    end
    base = n_launch;
    cmd_valid = 1'b1;
    cmd_pat = 8'h0F;
    cmd_duty = 8'd0;
    start = 1'b1;
    #1;
    ok = cmd_ready;
    if (ok) sb_q.push_back(16'h0F00);
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ready: got %b expected 1", ok);
    end
    step();
    cmd_valid = 1'b0;
    start = 1'b0;
    n_checks++;
    if (pwm_en !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_launch_latency: pwm_en got %b expected 1", pwm_en);
    end
    n_checks++;
    if (fifo_cnt !== 3'd1) begin
      n_errors++;
      $display("FAIL basic_push_pop_cnt: got %0d expected 1", fifo_cnt);
    end
    wait_seq_done(seen, dc);
    n_checks++;
    if (!seen || (n_launch - base) !== 2) begin
      n_errors++;
      $display("FAIL basic_done: seq_done=%b launches=%0d expected done with 2", seen, n_launch - base);
    end
    n_checks++;
    if ({fifo_cnt, seq_busy} !== {3'd0, 1'b0} || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL basic_end: cnt=%0d busy=%b left=%0d expected 0 0 0", fifo_cnt, seq_busy, sb_q.size());
    end
  endtask

  task automatic test_full();
    bit seen;
    int dc;
    int base;
    gap_num = 8'd0;
    for (int i = 0; i < 4; i++) push_one(8'h10 + 8'(i), 8'(i));
    n_checks++;
    if ({fifo_cnt, cmd_ready} !== {3'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL full_state: cnt=%0d ready=%b expected 4 0", fifo_cnt, cmd_ready);
    end
    base = n_launch;
    cmd_valid = 1'b1;
    cmd_pat = 8'h55;
    cmd_duty = 8'd7;
    start = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_reject: ready got %b expected 0", cmd_ready);
    end
    step();
    start = 1'b0;
    n_checks++;
    if ({fifo_cnt, cmd_ready} !== {3'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL full_after_pop: cnt=%0d ready=%b expected 3 1", fifo_cnt, cmd_ready);
    end
    if (cmd_ready) sb_q.push_back(16'h5507);
    step();
    cmd_valid = 1'b0;
    n_checks++;
    if (fifo_cnt !== 3'd4) begin
      n_errors++;
      $display("FAIL full_refill: cnt got %0d expected 4", fifo_cnt);
    end
    wait_seq_done(seen, dc);
    n_checks++;
    if (!seen || (n_launch - base) !== 5 || fifo_cnt !== 3'd0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL full_drain: done=%b launches=%0d cnt=%0d left=%0d expected 1 5 0 0",
               seen, n_launch - base, fifo_cnt, sb_q.size());
    end
  endtask

  task automatic test_loop();
    bit seen;
    int dc;
    int base;
    loop_en = 1'b1;
    gap_num = 8'd1;
    push_one(8'h81, 8'd2);
    base = n_launch;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL loop_ready_blocked: got %b expected 0", cmd_ready);
    end
    for (int i = 0; i < 100; i++) begin
      if ((n_launch - base) >= 3) break;
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_seq_done(seen, dc);
    n_checks++;
    if (!seen || (n_launch - base) !== 3) begin
      n_errors++;
      $display("FAIL loop_frames: done=%b launches=%0d expected 1 3", seen, n_launch - base);
    end
    n_checks++;
    if (fifo_cnt !== 3'd1 || sb_q.size() != 1) begin
      n_errors++;
      $display("FAIL loop_cnt: cnt=%0d model=%0d expected 1 1", fifo_cnt, sb_q.size());
    end
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_pat = 8'h99;
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    sb_q.delete();
    loop_en = 1'b0;
    n_checks++;
    if (fifo_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL flush_cnt: got %0d expected 0", fifo_cnt);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int dc;
    int base;
    eng_dead = 1'b1;
    push_one(8'h33, 8'd5);
    base = n_launch;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_seq_done(seen, dc);
    n_checks++;
    if (!seen || err !== 1'b1 || (n_launch - base) !== 1) begin
      n_errors++;
      $display("FAIL tmo_err: done=%b err=%b launches=%0d expected 1 1 1", seen, err, n_launch - base);
    end
    n_checks++;
    if ((dc - last_en_cyc) !== int'(TMO) + 1) begin
      n_errors++;
      $display("FAIL tmo_latency: got %0d expected %0d", dc - last_en_cyc, TMO + 1);
    end
    eng_dead = 1'b0;
    push_one(8'h44, 8'd2);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_sticky: err got %b expected 1", err);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_clear: err got %b expected 0", err);
    end
    wait_seq_done(seen, dc);
    n_checks++;
    if (!seen || err !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_recover: done=%b err=%b expected 1 0", seen, err);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    eng_len = 6;
    push_one(8'hC3, 8'd4);
    push_one(8'h3C, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if ({seq_busy, pwm_busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL rstmid_busy: seq_busy=%b pwm_busy=%b expected 1 1", seq_busy, pwm_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pwm_en, seq_busy, seq_done, err, fifo_cnt, pat_out, duty_out} !== 23'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: en=%b busy=%b done=%b err=%b cnt=%0d pat=%h duty=%h expected all 0",
               pwm_en, seq_busy, seq_done, err, fifo_cnt, pat_out, duty_out);
    end
    step();
    rst_n = 1'b1;
    eng_len = 3;
    sb_q.delete();
    step();
    base = n_launch;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    n_checks++;
    if ((n_launch - base) !== 0 || seq_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_empty_start: launches=%0d busy=%b expected 0 0", n_launch - base, seq_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_loop();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pattern_seq_ctrl.md
PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2).
REQ-002 SHALL have parameter TMO, default 4, cycles allowed from pwm_en to engine busy.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command push request.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a push.
REQ-007 SHALL have port cmd_pat  input  8  pattern for pushed command.
REQ-008 SHALL have port cmd_duty  input  8  duty count for pushed command.
REQ-009 SHALL have port start  input  1  pulse, begin playback.
REQ-010 SHALL have port stop  input  1  pulse, finish current frame then halt.
REQ-011 SHALL have port flush  input  1  clear FIFO, honoured only in IDLE.
REQ-012 SHALL have port loop_en  input  1  re-queue each launched command at FIFO tail.
REQ-013 SHALL have port gap_num  input  8  idle cycles between frames.
REQ-014 SHALL have port pwm_en  output  1  one-cycle launch pulse to PWM engine.
REQ-015 SHALL have port pat_out  output  8  PAT to engine.
REQ-016 SHALL have port duty_out  output  8  duty_num to engine.
REQ-017 SHALL have port pwm_busy  input  1  engine busy.
REQ-018 SHALL have port pwm_valid  input  1  engine frame-complete pulse.
REQ-019 SHALL have port seq_busy  output  1  state not IDLE.
REQ-020 SHALL have port seq_done  output  1  one-cycle pulse on return to IDLE.
REQ-021 SHALL have port fifo_cnt  output  log2(DEPTH)+1  entries held.
REQ-022 SHALL have port err  output  1  sticky engine-timeout flag.

Function
REQ-023 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP; all outputs registered.
REQ-024 SHALL push when cmd_valid && cmd_ready; cmd_ready = (fifo_cnt < DEPTH) && !(loop_en && seq_busy), from current-cycle count.
REQ-025 SHALL leave fifo_cnt unchanged on simultaneous push and pop.
REQ-026 SHALL go IDLE->LAUNCH on start when fifo_cnt != 0; start with empty FIFO, or start outside IDLE, ignored.
REQ-027 SHALL in LAUNCH pop FIFO head into pat_out/duty_out, assert pwm_en for exactly that one cycle, go WAIT_BUSY; pwm_en high the cycle after start sampled.
REQ-028 SHALL with loop_en=1 write the popped entry back to the FIFO tail in the same LAUNCH cycle (fifo_cnt unchanged).
REQ-029 SHALL hold pat_out/duty_out stable from LAUNCH until next LAUNCH.
REQ-030 SHALL in WAIT_BUSY go WAIT_DONE on pwm_busy=1; if not seen within TMO cycles after pwm_en, set err, pulse seq_done, go IDLE.
REQ-031 SHALL in WAIT_DONE go GAP on pwm_valid=1 (pwm_busy ignored).
REQ-032 SHALL in GAP count gap_num cycles (gap_num=0: one cycle), then LAUNCH if fifo_cnt != 0 and no stop pending, else IDLE with seq_done.
REQ-033 SHALL latch stop in any non-IDLE state as stop_pend; cleared on entering IDLE; current frame is never truncated.
REQ-034 SHALL clear FIFO (fifo_cnt=0) on flush in IDLE; flush in other states ignored; flush has priority over same-cycle push.
REQ-035 SHALL clear err on accepted start.

Reset
REQ-036 SHALL on rst_n=0 asynchronously force IDLE, fifo_cnt=0, pwm_en=0, pat_out=0, duty_out=0, seq_busy=0, seq_done=0, err=0, stop_pend=0, gap counter 0; cmd_ready=1 after reset.
REQ-037 SHALL on reset mid-frame drop all queued commands; pwm_en never asserted during reset.

Verification
REQ-038 Push (0xA5,3),(0x0F,0), gap_num=2, start -> two pwm_en pulses with pat_out 0xA5 then 0x0F, each after prior pwm_valid + 3 cycles, then seq_done, fifo_cnt=0.
REQ-039 Push 4 commands -> cmd_ready=0 at fifo_cnt=4; 5th push rejected; pop while cmd_valid held -> push accepted next cycle.
REQ-040 loop_en=1, one entry 0x81, start, stop after 3rd pwm_en -> exactly 3 frames, seq_done, fifo_cnt=1.
REQ-041 Engine model never raises pwm_busy -> err=1 and seq_done TMO+1 cycles after pwm_en; next start clears err.
REQ-042 Assert rst_n=0 during WAIT_DONE -> all outputs at reset values immediately, fifo_cnt=0; start after release with empty FIFO -> no pwm_en.
